// File: rtl/sseg_pkg.sv
// Shared types and active-low segment patterns for the BCD seven-segment driver.
// Bit order is {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digits_t [NUM_DIGITS-1:0];

    localparam logic [7:0] SSEG_0    = 8'hC0;
    localparam logic [7:0] SSEG_1    = 8'hF9;
    localparam logic [7:0] SSEG_2    = 8'hA4;
    localparam logic [7:0] SSEG_3    = 8'hB0;
    localparam logic [7:0] SSEG_4    = 8'h99;
    localparam logic [7:0] SSEG_5    = 8'h92;
    localparam logic [7:0] SSEG_6    = 8'h82;
    localparam logic [7:0] SSEG_7    = 8'hF8;
    localparam logic [7:0] SSEG_8    = 8'h80;
    localparam logic [7:0] SSEG_9    = 8'h90;
    localparam logic [7:0] SSEG_DASH = 8'hBF;
    localparam logic [7:0] SSEG_OFF  = 8'hFF;

    // True when any nibble lies outside the BCD range 0..9.
    function automatic logic has_invalid(input bcd_digits_t d);
        logic r;
        r = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (d[k[1:0]] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational nibble to active-low segment decoder; non-BCD values show a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] sseg_o
);

    always_comb begin
        sseg_o = SSEG_DASH;
        unique case (nibble_i)
            4'd0:    sseg_o = SSEG_0;
            4'd1:    sseg_o = SSEG_1;
            4'd2:    sseg_o = SSEG_2;
            4'd3:    sseg_o = SSEG_3;
            4'd4:    sseg_o = SSEG_4;
            4'd5:    sseg_o = SSEG_5;
            4'd6:    sseg_o = SSEG_6;
            4'd7:    sseg_o = SSEG_7;
            4'd8:    sseg_o = SSEG_8;
            4'd9:    sseg_o = SSEG_9;
            default: sseg_o = SSEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_mux.sv
// Four-digit multiplexed common-anode driver: latches a BCD reading on i_load
// and scans one digit per REFRESH_DIV cycles with optional leading-zero blanking.
module bcd_sseg_mux
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  bcd_digits_t i_freq_bcd,
    input  logic        i_blank_en,
    output logic [3:0]  o_an,
    output logic [7:0]  o_sseg,
    output logic        o_bcd_err
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    bcd_digits_t   shadow_q, shadow_d;
    logic          err_q, err_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;

    logic [7:0]    seg_dec;
    logic          upper_nz;
    logic          blank;

    bcd_to_sseg u_dec (
        .nibble_i (shadow_q[idx_q]),
        .sseg_o   (seg_dec)
    );

    // A digit above 0 is blanked only when it and every more significant digit is zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            if (k >= 32'(idx_q) && shadow_q[k[1:0]] != 4'd0) upper_nz = 1'b1;
        end
        blank = i_blank_en && (idx_q != 2'd0) && !upper_nz;
    end

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        if (i_load) begin
            shadow_d = i_freq_bcd;
            err_d    = has_invalid(i_freq_bcd);
        end
        // Outputs are built from the current state, giving one edge of latency
        // after both a load and an index advance.
        an_d   = blank ? '1 : ~(4'b0001 << idx_q);
        sseg_d = blank ? SSEG_OFF : seg_dec;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '{default: '0};
            err_q    <= 1'b0;
            an_q     <= '1;
            sseg_q   <= SSEG_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            an_q     <= an_d;
            sseg_q   <= sseg_d;
        end
    end

    assign o_an      = an_q;
    assign o_sseg    = sseg_q;
    assign o_bcd_err = err_q;

endmodule

// File: tb/tb_bcd_sseg_mux.sv
// Directed self-checking bench for bcd_sseg_mux with a 4-cycle digit slot.
module tb_bcd_sseg_mux;
    import sseg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load;
    bcd_digits_t freq;
    logic        blank_en;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        err;

    int checks;
    int failures;

    bcd_sseg_mux #(.REFRESH_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (load),
        .i_freq_bcd (freq),
        .i_blank_en (blank_en),
        .o_an       (an),
        .o_sseg     (sseg),
        .o_bcd_err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        freq[3] = d3;
        freq[2] = d2;
        freq[1] = d1;
        freq[0] = d0;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released; the next edge is E1.
    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        load     = 1'b1;
        blank_en = 1'b0;
        set_bcd(4'd8, 4'd8, 4'd8, 4'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (an !== 4'b1111 || sseg !== 8'hFF || err !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d an=%b sseg=%h err=%b want 1111/ff/0", i, an, sseg, err);
            end
        end
        load  = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (an !== 4'b1110 || sseg !== 8'hC0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release an=%b sseg=%h err=%b want 1110/c0/0", an, sseg, err);
        end
        tick();
        checks++;
        if (sseg !== 8'hC0) begin
            failures++;
            $display("FAIL reset_load_ignored sseg=%h want c0", sseg);
        end
    endtask

    task automatic test_full_scan();
        logic [3:0] exp_an   [4];
        logic [7:0] exp_sseg [4];
        int slot;
        exp_an   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_sseg = '{8'hF8, 8'hC0, 8'hC0, 8'h99};
        do_reset();
        blank_en = 1'b0;
        set_bcd(4'd4, 4'd0, 4'd0, 4'd7);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int e = 2; e <= 17; e++) begin
            tick();
            slot = ((e - 1) / 4) % 4;
            checks++;
            if (an !== exp_an[slot] || sseg !== exp_sseg[slot]) begin
                failures++;
                $display("FAIL full_scan edge=%0d an=%b sseg=%h want %b/%h",
                         e, an, sseg, exp_an[slot], exp_sseg[slot]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] exp_an   [4];
        logic [7:0] exp_sseg [4];
        int slot;
        exp_an   = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        exp_sseg = '{8'h92, 8'hA4, 8'hFF, 8'hFF};
        do_reset();
        blank_en = 1'b1;
        set_bcd(4'd0, 4'd0, 4'd2, 4'd5);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int e = 2; e <= 16; e++) begin
            tick();
            slot = ((e - 1) / 4) % 4;
            checks++;
            if (an !== exp_an[slot] || sseg !== exp_sseg[slot]) begin
                failures++;
                $display("FAIL blank_25 edge=%0d an=%b sseg=%h want %b/%h",
                         e, an, sseg, exp_an[slot], exp_sseg[slot]);
            end
        end
        do_reset();
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int e = 2; e <= 16; e++) begin
            tick();
            slot = ((e - 1) / 4) % 4;
            checks++;
            if ((slot == 0 && (an !== 4'b1110 || sseg !== 8'hC0)) ||
                (slot != 0 && (an !== 4'b1111 || sseg !== 8'hFF))) begin
                failures++;
                $display("FAIL blank_zero edge=%0d an=%b sseg=%h slot=%0d", e, an, sseg, slot);
            end
        end
        blank_en = 1'b0;
    endtask

    task automatic test_invalid();
        do_reset();
        blank_en = 1'b0;
        set_bcd(4'd0, 4'hC, 4'd3, 4'd1);
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set err=%b want 1", err);
        end
        repeat (8) tick();
        checks++;
        if (an !== 4'b1011 || sseg !== 8'hBF || err !== 1'b1) begin
            failures++;
            $display("FAIL dash_digit an=%b sseg=%h err=%b want 1011/bf/1", an, sseg, err);
        end
        set_bcd(4'd0, 4'd0, 4'd0, 4'd1);
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b want 0", err);
        end
    endtask

    task automatic test_slot_boundary();
        do_reset();
        blank_en = 1'b0;
        repeat (3) tick();
        set_bcd(4'd8, 4'd8, 4'd8, 4'd8);
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (an !== 4'b1110 || sseg !== 8'hC0) begin
            failures++;
            $display("FAIL boundary_wrap an=%b sseg=%h want 1110/c0", an, sseg);
        end
        tick();
        checks++;
        if (an !== 4'b1101 || sseg !== 8'h80) begin
            failures++;
            $display("FAIL boundary_next an=%b sseg=%h want 1101/80", an, sseg);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_sseg [3];
        exp_sseg = '{8'hF9, 8'hA4, 8'hB0};
        do_reset();
        blank_en = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_bcd(4'd0, 4'd0, 4'd0, 4'(i + 1));
            tick();
            if (i > 0) begin
                checks++;
                if (sseg !== exp_sseg[i - 1]) begin
                    failures++;
                    $display("FAIL back_to_back i=%0d sseg=%h want %h", i, sseg, exp_sseg[i - 1]);
                end
            end
        end
        load = 1'b0;
        tick();
        checks++;
        if (sseg !== exp_sseg[2] || an !== 4'b1110) begin
            failures++;
            $display("FAIL back_to_back_last an=%b sseg=%h want 1110/%h", an, sseg, exp_sseg[2]);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        blank_en = 1'b0;
        set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (8) tick();
        checks++;
        if (an !== 4'b1011 || sseg !== 8'hA4) begin
            failures++;
            $display("FAIL mid_scan_pre an=%b sseg=%h want 1011/a4", an, sseg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || sseg !== 8'hFF || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset an=%b sseg=%h err=%b want 1111/ff/0", an, sseg, err);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if ((e <= 4 && (an !== 4'b1110 || sseg !== 8'hC0)) ||
                (e == 5 && (an !== 4'b1101 || sseg !== 8'hC0))) begin
                failures++;
                $display("FAIL mid_scan_restart edge=%0d an=%b sseg=%h", e, an, sseg);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        blank_en = 1'b0;
        set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_full_scan();
        test_blanking();
        test_invalid();
        test_slot_boundary();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_sseg_mux.md
# bcd_sseg_mux

Time-multiplexed 4-digit seven-segment driver that consumes the four BCD digits produced by `low_freq_counter`. It latches a new reading on a one-cycle load strobe and scans the digits onto common-anode displays. Leading-zero blanking is optional, and digit values above 9 are flagged as invalid. It sits directly downstream of the frequency counter and drives the board's anode and segment pins.

## Interface
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays lit. This is 1 ms at 100 MHz. Legal range is ≥ 2.
- `i_clk`  in  1: system clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_load`  in  1: one-cycle strobe; capture `i_freq_bcd` this cycle.
- `i_freq_bcd`  in  4×4 (unpacked `[3:0]` of `logic [3:0]`): digit 0 is least significant.
- `i_blank_en`  in  1: 1 enables leading-zero blanking.
- `o_an`  out  4: anode enables, active-low, one-hot-low when lit.
- `o_sseg`  out  8: segments, active-low, `{dp,g,f,e,d,c,b,a}`.
- `o_bcd_err`  out  1: latched value contains a nibble > 9.

## Operation
- **Shadow register**
  - On a clock edge with `i_load` = 1, all four nibbles of `i_freq_bcd` are copied into the shadow register.
  - `o_bcd_err` is updated on that same edge to the OR of (nibble > 9).
  - Without `i_load`, the shadow register and `o_bcd_err` hold their values.
- **Refresh counter**
  - Width is `$clog2(REFRESH_DIV)`. It counts 0..REFRESH_DIV-1, then wraps to 0.
  - On each wrap, the 2-bit digit index advances 0→1→2→3→0.
- **Digit decode**
  - The current digit's nibble maps to active-low segments:
    - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
    - Nibbles 10–15 display a dash, BF.
  - dp is always off (bit 7 = 1).
- **Blanking**
  - When `i_blank_en` = 1, digit k ≥ 1 is blanked if digits k..3 of the shadow register are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives `o_an` = 4'b1111 and `o_sseg` = 8'hFF for its whole slot. The scan timing does not change.
- **Lit digit**
  - `o_an` drives bit[index] low and the other bits high.
- **Simultaneous load and index advance:** both take effect on the same edge. The new digit's segments come from the new shadow value.
- **Reset**
  - Asynchronous assertion immediately forces:
    - shadow = 0, counter = 0, index = 0;
    - `o_an` = 4'b1111, `o_sseg` = 8'hFF, `o_bcd_err` = 0.
  - This applies mid-scan and mid-load alike. An `i_load` coincident with reset is ignored.

## Timing
- `o_an`, `o_sseg` and `o_bcd_err` are registered. There is no combinational path from any input to any output.
- **After reset:** on the first edge after `i_rst_n` deasserts, `o_an` = 4'b1110 and `o_sseg` = C0.
- **Load latency:**
  - `i_load` sampled at edge N updates the shadow register at N and `o_bcd_err` at N.
  - `o_sseg` and `o_an` reflect the new value at edge N+1.
- **Index latency:** the index changes at the edge where the counter wraps. `o_an` and `o_sseg` follow one edge later.
- **Slot length:** each digit is visible for exactly REFRESH_DIV cycles, and a full frame lasts 4·REFRESH_DIV cycles.
- **Handshake:** `i_load` has no back-pressure and is accepted every cycle. Consecutive loads are legal, and the last one wins.

## Structure
- Package `sseg_pkg`:
  - typedef `bcd_digits_t` (`logic [3:0]` ×4);
  - segment constants `SSEG_0`..`SSEG_9`, `SSEG_DASH`, `SSEG_OFF`;
  - `NUM_DIGITS` = 4.
- Sub-module `bcd_to_sseg`: a combinational nibble→8-bit active-low pattern decoder that includes the dash mapping. It is instantiated once, fed by the index mux.
- Everything else is in the top: counter, index, shadow register, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV = 4.
- **Reset.** Stimulus: hold `i_rst_n` = 0 for 3 cycles, then release. Response: `o_an` = 1111 and `o_sseg` = FF during reset. One edge after release, `o_an` = 1110 and `o_sseg` = C0. `o_bcd_err` = 0.
- **Full scan.** Stimulus: load {4,0,0,7} (digit3..0) with `i_blank_en` = 0. Response: over one frame, `o_an`/`o_sseg` sequence is 1110/F8, 1101/C0, 1011/C0, 0111/99, each held 4 cycles.
- **Blanking.** Stimulus: load {0,0,2,5} with `i_blank_en` = 1. Response: slots 0–1 show F9... no: slot 0 shows 92 ("5"), slot 1 shows A4 ("2"). Slots 2–3 show `o_an` = 1111 and `o_sseg` = FF. Loading 0000 shows only slot 0 lit with C0.
- **Invalid digit.** Stimulus: load {0,0xC,3,1}. Response: `o_bcd_err` = 1 on the load edge, and digit 2 shows BF. A subsequent load of {0,0,0,1} clears `o_bcd_err` on its edge.
- **Load at slot boundary.** Stimulus: assert `i_load` with 8888 on the same edge the counter wraps to index 1. Response: next edge shows `o_an` = 1101 and `o_sseg` = 80.
- **Reset mid-scan.** Stimulus: pull `i_rst_n` low between edges while index = 2. Response: outputs go to 1111/FF without waiting for a clock edge. After release, the scan restarts at index 0 and displays 0.
